// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked successor to the 4-bit combinational ALU.
// Takes one operation per valid/ready transaction. ADD/SUB/logic/shift ops finish
// in a single cycle. MUL is an unsigned shift-add taking WIDTH cycles. The result
// and Z/C/V/S flags are held until the consumer takes them.
// Optional feature macro: ALU_SEQ_SEVSEG_EN (registered hex decode of result[3:0]
// onto sevenSeg). When it is undefined, sevenSeg is tied blank.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             S,
    output logic             busy,
    output logic [6:0]       sevenSeg
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d, c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0]   mulA_q, mulA_d, mulB_q, mulB_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]     sumW, diffW, shlW, shrW;
    logic [SHW-1:0]     shAmt;
    logic [WIDTH-1:0]   aluRes;
    logic               aluC, aluV;
    logic [2*WIDTH-1:0] addend, prodStep;

    // Single-cycle datapath; the extra top/bottom bit of each shift captures the last bit shifted out
    always_comb begin
        shAmt  = b[SHW-1:0];
        sumW   = {1'b0, a} + {1'b0, b};
        diffW  = {1'b0, a} - {1'b0, b};
        shlW   = {1'b0, a} << shAmt;
        shrW   = {a, 1'b0} >> shAmt;
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        case (op)
            OP_ADD: begin
                aluRes = sumW[WIDTH-1:0];
                aluC   = sumW[WIDTH];
                aluV   = (a[WIDTH-1] == b[WIDTH-1]) && (sumW[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes = diffW[WIDTH-1:0];
                aluC   = diffW[WIDTH];
                aluV   = (a[WIDTH-1] != b[WIDTH-1]) && (diffW[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: aluRes = a & b;
            OP_OR:  aluRes = a | b;
            OP_XOR: aluRes = a ^ b;
            OP_SHL: begin
                aluRes = shlW[WIDTH-1:0];
                aluC   = shlW[WIDTH];
            end
            OP_SHR: begin
                aluRes = shrW[WIDTH:1];
                aluC   = shrW[0];
            end
            default: begin
            end
        endcase
    end

    // One shift-add multiply step: add A shifted by the current bit position when that bit of B is set
    always_comb begin
        addend   = mulB_q[cnt_q] ? ({{WIDTH{1'b0}}, mulA_q} << cnt_q) : '0;
        prodStep = prod_q + addend;
    end

    // Next-state logic for the IDLE -> (MUL) -> DONE transaction sequence
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        mulA_d   = mulA_q;
        mulB_d   = mulB_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mulA_d  = a;
                        mulB_d  = b;
                        prod_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_MUL;
                    end else begin
                        result_d = aluRes;
                        z_d      = (aluRes == '0);
                        c_d      = aluC;
                        v_d      = aluV;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                prod_d = prodStep;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d = prodStep[WIDTH-1:0];
                    z_d      = (prodStep[WIDTH-1:0] == '0);
                    c_d      = |prodStep[2*WIDTH-1:WIDTH];
                    v_d      = |prodStep[2*WIDTH-1:WIDTH];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            mulA_q   <= '0;
            mulB_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            mulA_q   <= mulA_d;
            mulB_q   <= mulB_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL);
    assign result    = result_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;
    assign S         = result_q[WIDTH-1];

`ifdef ALU_SEQ_SEVSEG_EN
    logic [6:0] seg_q, seg_d;

    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Segment pattern follows the next result so it changes on the same edge as result
    always_comb begin
        seg_d = hexToSeg(result_d[3:0]);
    end

    // Segment register resets to the pattern for 0, matching the cleared result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h3F;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign sevenSeg = seg_q;
`else
    assign sevenSeg = 7'h00;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8).
// Stimulus pushes the expected response from an arithmetic reference model;
// a separate monitor pops it when out_valid rises and compares result, flags,
// latency, busy duration and segment drive.
module tb_alu_seq;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        int res;
        int z;
        int c;
        int v;
        int s;
        int acceptCyc;
        int lat;
        int busyExp;
    } exp_t;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [2:0]   opIn;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic         zFlag, cFlag, vFlag, sFlag;
    logic         busy;
    logic [6:0]   sevenSeg;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .op        (opIn),
        .a         (aIn),
        .b         (bIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (result),
        .Z         (zFlag),
        .C         (cFlag),
        .V         (vFlag),
        .S         (sFlag),
        .busy      (busy),
        .sevenSeg  (sevenSeg)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance-to-output latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic int expSeg(input int res);
`ifdef ALU_SEQ_SEVSEG_EN
        return int'(segTable[res & 15]);
`else
        return 0;
`endif
    endfunction

    function automatic int toSigned(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference model written from the arithmetic rules with plain integers
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   full, sres, sh;
        e.c = 0;
        e.v = 0;
        sh = b % W;
        case (op)
            0: begin
                full = a + b;
                e.res = full & MASK;
                e.c = (full > MASK) ? 1 : 0;
                sres = toSigned(a) + toSigned(b);
                e.v = (sres > (1 << (W - 1)) - 1 || sres < -(1 << (W - 1))) ? 1 : 0;
            end
            1: begin
                e.res = (a - b) & MASK;
                e.c = (a < b) ? 1 : 0;
                sres = toSigned(a) - toSigned(b);
                e.v = (sres > (1 << (W - 1)) - 1 || sres < -(1 << (W - 1))) ? 1 : 0;
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: begin
                e.res = (a << sh) & MASK;
                e.c = (sh == 0) ? 0 : ((a >> (W - sh)) & 1);
            end
            6: begin
                e.res = a >> sh;
                e.c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
            end
            default: begin
                full = a * b;
                e.res = full & MASK;
                e.c = (full > MASK) ? 1 : 0;
                e.v = e.c;
            end
        endcase
        e.z = (e.res == 0) ? 1 : 0;
        e.s = (e.res >> (W - 1)) & 1;
        e.lat = (op == 7) ? W + 1 : 1;
        e.busyExp = (op == 7) ? W : 0;
        e.acceptCyc = 0;
        return e;
    endfunction

    // Monitor: pop and compare whenever a new result is presented
    bit seen = 1'b0;
    int busyCnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstN) begin
            seen = 1'b0;
            busyCnt = 0;
        end else begin
            if (busy) busyCnt++;
            if (outValid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", int'(result), -1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", int'(result), e.res);
                    checkOutput("Z", int'(zFlag), e.z);
                    checkOutput("C", int'(cFlag), e.c);
                    checkOutput("V", int'(vFlag), e.v);
                    checkOutput("S", int'(sFlag), e.s);
                    checkOutput("latency", cyc - e.acceptCyc, e.lat);
                    checkOutput("busy_cycles", busyCnt, e.busyExp);
                    checkOutput("sevenSeg", int'(sevenSeg), expSeg(e.res));
                end
                busyCnt = 0;
            end else if (!outValid) begin
                seen = 1'b0;
            end
        end
    end

    // Present one operation when the block is ready; optionally record its expectation
    task automatic issueOp(input int op, input int a, input int b, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        inValid = 1'b1;
        opIn = 3'(op);
        aIn = W'(a);
        bIn = W'(b);
        if (push) begin
            e = model(op, a, b);
            e.acceptCyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        inValid = 1'b0;
        opIn = 3'($urandom_range(0, 7));
        aIn = W'($urandom_range(0, MASK));
        bIn = W'($urandom_range(0, MASK));
    endtask

    task automatic waitOutValid();
        int n = 0;
        while (!outValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!outValid) checkOutput("out_valid_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int op, input int a, input int b, input int hold);
        issueOp(op, a, b, 1'b1);
        waitOutValid();
        repeat (hold) @(negedge clk);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    // Main stimulus sequence
    initial begin
        exp_t bp;
        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        opIn = '0;
        aIn = '0;
        bIn = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", int'(inReady), 1);
        checkOutput("reset_out_valid", int'(outValid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_result", int'(result), 0);
        checkOutput("reset_flags", int'({zFlag, cFlag, vFlag, sFlag}), 0);
        checkOutput("reset_sevenSeg", int'(sevenSeg), expSeg(0));
        rstN = 1'b1;

        applyStimulus(0, 'h7F, 'h01, 0);
        applyStimulus(1, 'h03, 'h05, 1);
        applyStimulus(1, 'h05, 'h05, 0);
        applyStimulus(7, 'h10, 'h11, 2);
        applyStimulus(7, 'h0F, 'h03, 0);
        applyStimulus(5, 'h81, 1, 0);
        applyStimulus(6, 'h81, 0, 0);
        applyStimulus(6, 'h81, 7, 0);
        applyStimulus(5, 'hFF, 7, 0);

        // Backpressure: result must hold while inputs churn and the consumer stalls
        bp = model(4, 'hA5, 'h3C);
        issueOp(4, 'hA5, 'h3C, 1'b1);
        waitOutValid();
        for (int i = 0; i < 5; i++) begin
            inValid = 1'($urandom_range(0, 1));
            opIn = 3'($urandom_range(0, 7));
            aIn = W'($urandom_range(0, MASK));
            bIn = W'($urandom_range(0, MASK));
            @(negedge clk);
            checkOutput("bp_result", int'(result), bp.res);
            checkOutput("bp_flags", int'({zFlag, cFlag, vFlag, sFlag}), (bp.z << 3) | (bp.c << 2) | (bp.v << 1) | bp.s);
            checkOutput("bp_in_ready", int'(inReady), 0);
            checkOutput("bp_out_valid", int'(outValid), 1);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("bp_release_in_ready", int'(inReady), 1);
        checkOutput("bp_release_out_valid", int'(outValid), 0);

        // Reset in the middle of a multiply: nothing may come out afterwards
        issueOp(7, 'h10, 'h11, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", int'(busy), 1);
        rstN = 1'b0;
        #1;
        checkOutput("abort_in_ready", int'(inReady), 1);
        checkOutput("abort_out_valid", int'(outValid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_result", int'(result), 0);
        checkOutput("abort_flags", int'({zFlag, cFlag, vFlag, sFlag}), 0);
        @(negedge clk);
        rstN = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checkOutput("abort_no_stale", int'(outValid), 0);
        end
        outReady = 1'b0;

        // Randomised operations with random consumer stall
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 7), $urandom_range(0, MASK), $urandom_range(0, MASK),
                          $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
